// File: rtl/udp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_sched
// Description : Round-robin packet scheduler feeding a UDP TX engine with
//               2-byte frequency words and fixed-length waveform payloads.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_sched #(
    parameter int unsigned WAVE_BYTES     = 1024,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic        freq_valid,
    input  logic [15:0] wave_freq,
    input  logic [13:0] fifo_rd_count,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_dout,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        udp_tx_req,
    output logic [7:0]  udp_tx_data,
    input  logic        udp_tx_done,
    output logic        busy,
    output logic [7:0]  freq_ovr_cnt,
    output logic        timeout_err
);

    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_GAP  = 2'd1;
    localparam logic [1:0]  c_ST_FREQ = 2'd2;
    localparam logic [1:0]  c_ST_WAVE = 2'd3;

    localparam logic [13:0] c_WAVE_BYTES   = 14'(WAVE_BYTES);
    localparam logic [15:0] c_WAVE_LEN     = 16'(WAVE_BYTES);
    localparam logic [19:0] c_TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
    localparam int unsigned c_GAP_W        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST =
        (GAP_CYCLES > 1) ? c_GAP_W'(GAP_CYCLES - 1) : '0;

    logic [1:0]         r_state;
    logic [15:0]        r_freq_hold;
    logic [15:0]        r_send;
    logic               r_freq_pend;
    logic               r_last_freq;
    logic [13:0]        r_rd_cnt;
    logic [19:0]        r_to_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [1:0]         r_req_cnt;
    logic [7:0]         r_data;
    logic               r_rd_d;
    logic [7:0]         r_ovr_cnt;
    logic               r_timeout_err;

    logic w_wave_elig;
    logic w_grant_freq;
    logic w_grant_wave;
    logic w_gap_done;

    // On a tie the requester that was not served last wins.
    assign w_wave_elig  = (fifo_rd_count >= c_WAVE_BYTES);
    assign w_grant_freq = (r_state == c_ST_IDLE) && r_freq_pend && (!w_wave_elig || !r_last_freq);
    assign w_grant_wave = (r_state == c_ST_IDLE) && w_wave_elig && (!r_freq_pend || r_last_freq);
    assign w_gap_done   = (GAP_CYCLES <= 1) || (r_gap_cnt == c_GAP_LAST);

    assign fifo_rd_en   = (r_state == c_ST_WAVE) && udp_tx_req && (r_rd_cnt < c_WAVE_BYTES);
    assign udp_tx_data  = (r_rd_d && (r_state == c_ST_WAVE)) ? fifo_dout : r_data;
    assign busy         = (r_state != c_ST_IDLE);
    assign freq_ovr_cnt = r_ovr_cnt;
    assign timeout_err  = r_timeout_err;

    // A strobe coinciding with the freq grant refills the hold register without an overrun.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            r_freq_hold <= '0;
            r_send      <= '0;
            r_freq_pend <= 1'b0;
            r_ovr_cnt   <= '0;
        end else begin
            if (w_grant_freq) begin
                r_send <= r_freq_hold;
            end
            if (freq_valid) begin
                r_freq_hold <= wave_freq;
                r_freq_pend <= 1'b1;
                if (r_freq_pend && !w_grant_freq && (r_ovr_cnt != 8'hFF)) begin
                    r_ovr_cnt <= r_ovr_cnt + 8'd1;
                end
            end else if (w_grant_freq) begin
                r_freq_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            tx_start_en   <= 1'b0;
            tx_byte_num   <= '0;
            r_last_freq   <= 1'b0;
            r_rd_cnt      <= '0;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_req_cnt     <= '0;
            r_data        <= '0;
            r_rd_d        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            tx_start_en <= 1'b0;
            r_data      <= 8'h00;
            r_rd_d      <= fifo_rd_en;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_freq || w_grant_wave) begin
                        r_state     <= w_grant_freq ? c_ST_FREQ : c_ST_WAVE;
                        tx_byte_num <= w_grant_freq ? 16'd2 : c_WAVE_LEN;
                        r_last_freq <= w_grant_freq;
                        tx_start_en <= 1'b1;
                        r_rd_cnt    <= '0;
                        r_to_cnt    <= '0;
                        r_req_cnt   <= '0;
                    end
                end
                c_ST_FREQ, c_ST_WAVE: begin
                    if ((r_state == c_ST_FREQ) && udp_tx_req) begin
                        case (r_req_cnt)
                            2'd0:    r_data <= r_send[15:8];
                            2'd1:    r_data <= r_send[7:0];
                            default: r_data <= 8'h00;
                        endcase
                        if (r_req_cnt != 2'd2) begin
                            r_req_cnt <= r_req_cnt + 2'd1;
                        end
                    end
                    if (fifo_rd_en) begin
                        r_rd_cnt <= r_rd_cnt + 14'd1;
                    end
                    if (udp_tx_done) begin
                        r_state   <= c_ST_GAP;
                        r_gap_cnt <= '0;
                    end else if (r_to_cnt == c_TIMEOUT_LAST) begin
                        r_state       <= c_ST_GAP;
                        r_gap_cnt     <= '0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 20'd1;
                    end
                end
                c_ST_GAP: begin
                    if (w_gap_done) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_tx_sched
// Description : Directed/randomised bench acting as UDP engine and FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_sched;

    localparam int c_WAVE = 1024;
    localparam int c_GAP  = 16;

    logic        clk_125m = 1'b0;
    logic        rst_n = 1'b0;
    logic        freq_valid = 1'b0;
    logic [15:0] wave_freq = '0;
    logic [13:0] fifo_rd_count = '0;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout = '0;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        udp_tx_req = 1'b0;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_done = 1'b0;
    logic        busy;
    logic [7:0]  freq_ovr_cnt;
    logic        timeout_err;

    logic        freq_valid2 = 1'b0;
    logic [15:0] wave_freq2 = '0;
    logic [13:0] fifo_rd_count2 = '0;
    logic        fifo_rd_en2;
    logic [7:0]  fifo_dout2 = '0;
    logic        tx_start_en2;
    logic [15:0] tx_byte_num2;
    logic        udp_tx_req2 = 1'b0;
    logic [7:0]  udp_tx_data2;
    logic        udp_tx_done2 = 1'b0;
    logic        busy2;
    logic [7:0]  freq_ovr_cnt2;
    logic        timeout_err2;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_rd = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] last_word = '0;

    always #4 clk_125m = ~clk_125m;

    udp_tx_sched #(.WAVE_BYTES(c_WAVE), .GAP_CYCLES(c_GAP), .TIMEOUT_CYCLES(1000000)) dut (
        .clk_125m(clk_125m), .rst_n(rst_n), .freq_valid(freq_valid), .wave_freq(wave_freq),
        .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .udp_tx_req(udp_tx_req),
        .udp_tx_data(udp_tx_data), .udp_tx_done(udp_tx_done), .busy(busy),
        .freq_ovr_cnt(freq_ovr_cnt), .timeout_err(timeout_err));

    udp_tx_sched #(.WAVE_BYTES(c_WAVE), .GAP_CYCLES(c_GAP), .TIMEOUT_CYCLES(100)) dut_to (
        .clk_125m(clk_125m), .rst_n(rst_n), .freq_valid(freq_valid2), .wave_freq(wave_freq2),
        .fifo_rd_count(fifo_rd_count2), .fifo_rd_en(fifo_rd_en2), .fifo_dout(fifo_dout2),
        .tx_start_en(tx_start_en2), .tx_byte_num(tx_byte_num2), .udp_tx_req(udp_tx_req2),
        .udp_tx_data(udp_tx_data2), .udp_tx_done(udp_tx_done2), .busy(busy2),
        .freq_ovr_cnt(freq_ovr_cnt2), .timeout_err(timeout_err2));

    // FIFO model with one-cycle read latency
    always @(posedge clk_125m) begin
        if (fifo_rd_en === 1'b1) begin
            n_rd <= n_rd + 1;
            fifo_dout <= (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_bytes(input bit seq);
        for (int i = 0; i < c_WAVE; i++) begin
            logic [7:0] b;
            b = seq ? 8'(i) : 8'($urandom);
            fifo_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    // Acts as the UDP engine for one packet; ends with a one-cycle done strobe.
    task automatic run_packet(input string tag, input bit is_wave, input logic [15:0] fword,
                              input int nreq, input int n_str, input bit drop_count);
        int n, issued, rd0, strobes, exp_reads;
        bit pend_chk;
        logic [7:0] exp_d;
        n = 0;
        while (tx_start_en !== 1'b1 && n < 400) begin
            @(negedge clk_125m);
            n++;
        end
        check({tag, " start"}, 32'(tx_start_en), 32'd1);
        check({tag, " byte_num"}, 32'(tx_byte_num), is_wave ? 32'(c_WAVE) : 32'd2);
        check({tag, " busy"}, 32'(busy), 32'd1);
        if (drop_count) fifo_rd_count = '0;
        rd0 = n_rd;
        issued = 0;
        strobes = 0;
        pend_chk = 0;
        exp_d = '0;
        @(negedge clk_125m);
        check({tag, " start_width"}, 32'(tx_start_en), 32'd0);
        while (issued < nreq || pend_chk) begin
            if (pend_chk) begin
                check({tag, " data"}, 32'(udp_tx_data), 32'(exp_d));
                pend_chk = 0;
            end
            freq_valid = 1'b0;
            if (issued < nreq && $urandom_range(0, 3) != 0) begin
                udp_tx_req = 1'b1;
                if (is_wave)
                    exp_d = (issued < c_WAVE && exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                else
                    exp_d = (issued == 0) ? fword[15:8] : (issued == 1) ? fword[7:0] : 8'h00;
                issued++;
                pend_chk = 1;
                if (is_wave && strobes < n_str && issued == 100 * (strobes + 1)) begin
                    freq_valid = 1'b1;
                    wave_freq = 16'($urandom);
                    last_word = wave_freq;
                    strobes++;
                end
            end else begin
                udp_tx_req = 1'b0;
            end
            @(negedge clk_125m);
        end
        udp_tx_req = 1'b0;
        freq_valid = 1'b0;
        exp_reads = is_wave ? ((nreq < c_WAVE) ? nreq : c_WAVE) : 0;
        check({tag, " reads"}, 32'(n_rd - rd0), 32'(exp_reads));
        udp_tx_done = 1'b1;
        @(negedge clk_125m);
        udp_tx_done = 1'b0;
    endtask

    // Measures the post-packet gap; optionally strobes a freq word in the IDLE cycle.
    task automatic wait_gap(input string tag, input bit strobe, input logic [15:0] w);
        int g;
        g = 0;
        while (busy === 1'b1 && g < 100) begin
            if (g == 0) check({tag, " gap_data"}, 32'(udp_tx_data), 32'd0);
            g++;
            @(negedge clk_125m);
        end
        check({tag, " gap_len"}, 32'(g), 32'(c_GAP));
        if (strobe) begin
            freq_valid = 1'b1;
            wave_freq = w;
            @(negedge clk_125m);
            freq_valid = 1'b0;
        end
    endtask

    initial begin
        int n, rd0, rd_snap, g;
        logic [15:0] w1, w_e;

        // Reset values
        repeat (3) @(negedge clk_125m);
        check("rst tx_start_en", 32'(tx_start_en), 32'd0);
        check("rst fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("rst udp_tx_data", 32'(udp_tx_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst freq_ovr_cnt", 32'(freq_ovr_cnt), 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_125m);
        check("idle busy", 32'(busy), 32'd0);

        // Single freq packet, with one surplus request
        freq_valid = 1'b1;
        wave_freq = 16'h1234;
        @(negedge clk_125m);
        freq_valid = 1'b0;
        run_packet("freq1234", 1'b0, 16'h1234, 3, 0, 1'b0);
        wait_gap("freq1234", 1'b0, '0);

        // Wave packet, bytes 0..255 repeating, exactly WAVE_BYTES requests
        push_bytes(1'b1);
        fifo_rd_count = 14'(c_WAVE);
        run_packet("wave_seq", 1'b1, '0, c_WAVE, 0, 1'b1);
        wait_gap("wave_seq", 1'b0, '0);

        // Wave packet with random data and requests beyond the payload length
        push_bytes(1'b0);
        fifo_rd_count = 14'(c_WAVE);
        run_packet("wave_extra", 1'b1, '0, c_WAVE + int'($urandom_range(1, 5)), 0, 1'b1);
        wait_gap("wave_extra", 1'b0, '0);

        // Round-robin from reset, overrun counting, grant-cycle strobe
        rst_n = 1'b0;
        repeat (2) @(negedge clk_125m);
        rst_n = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        w1 = 16'($urandom);
        w_e = 16'($urandom);
        freq_valid = 1'b1;
        wave_freq = w1;
        @(negedge clk_125m);
        freq_valid = 1'b0;
        push_bytes(1'b0);
        fifo_rd_count = 14'(c_WAVE);
        run_packet("rr1_freq", 1'b0, w1, 2, 0, 1'b0);
        wait_gap("rr1_freq", 1'b0, '0);
        run_packet("rr2_wave", 1'b1, '0, c_WAVE, 3, 1'b0);
        check("ovr after 3 strobes", 32'(freq_ovr_cnt), 32'd2);
        wait_gap("rr2_wave", 1'b1, w_e);
        run_packet("rr3_freq", 1'b0, last_word, 2, 0, 1'b1);
        wait_gap("rr3_freq", 1'b0, '0);
        run_packet("rr4_freq", 1'b0, w_e, 2 + int'($urandom_range(0, 2)), 0, 1'b0);
        wait_gap("rr4_freq", 1'b0, '0);
        check("ovr unchanged by grant strobe", 32'(freq_ovr_cnt), 32'd2);

        // Done-timeout on the short-timeout instance
        freq_valid2 = 1'b1;
        wave_freq2 = 16'($urandom);
        @(negedge clk_125m);
        freq_valid2 = 1'b0;
        n = 0;
        while (tx_start_en2 !== 1'b1 && n < 10) begin
            @(negedge clk_125m);
            n++;
        end
        check("to start", 32'(tx_start_en2), 32'd1);
        repeat (99) @(negedge clk_125m);
        check("to err before limit", 32'(timeout_err2), 32'd0);
        @(negedge clk_125m);
        check("to err at limit", 32'(timeout_err2), 32'd1);
        check("to busy in gap", 32'(busy2), 32'd1);
        g = 0;
        while (busy2 === 1'b1 && g < 100) begin
            g++;
            @(negedge clk_125m);
        end
        check("to gap_len", 32'(g), 32'(c_GAP));
        check("to err sticky", 32'(timeout_err2), 32'd1);

        // Reset asserted at byte 500 of a wave packet
        fifo_q.delete();
        exp_q.delete();
        push_bytes(1'b0);
        fifo_rd_count = 14'(c_WAVE);
        n = 0;
        while (tx_start_en !== 1'b1 && n < 400) begin
            @(negedge clk_125m);
            n++;
        end
        check("abort start", 32'(tx_start_en), 32'd1);
        rd0 = n_rd;
        udp_tx_req = 1'b1;
        n = 0;
        while ((n_rd - rd0) < 500 && n < 2000) begin
            @(negedge clk_125m);
            n++;
        end
        check("abort reads before reset", 32'(n_rd - rd0), 32'd500);
        rst_n = 1'b0;
        #1;
        check("abort fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("abort tx_start_en", 32'(tx_start_en), 32'd0);
        check("abort tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("abort udp_tx_data", 32'(udp_tx_data), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort freq_ovr_cnt", 32'(freq_ovr_cnt), 32'd0);
        check("abort timeout_err2", 32'(timeout_err2), 32'd0);
        fifo_rd_count = '0;
        rd_snap = n_rd;
        repeat (4) @(negedge clk_125m);
        rst_n = 1'b1;
        repeat (30) begin
            udp_tx_req = 1'($urandom_range(0, 1));
            @(negedge clk_125m);
        end
        udp_tx_req = 1'b0;
        check("abort no reads after", 32'(n_rd - rd_snap), 32'd0);
        check("abort idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udp_tx_sched.md
UDP_TX_SCHED -- requirements
Module: udp_tx_sched

Interface
REQ-001 SHALL have parameter WAVE_BYTES, default 1024, meaning the waveform packet payload length in bytes (legal range 2..8192).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning the minimum idle cycles between udp_tx_done and the next tx_start_en.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum cycles to wait for udp_tx_done after a start.
REQ-004 SHALL have port clk_125m, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port freq_valid, input, 1 bit: one-cycle strobe marking a new wave_freq value.
REQ-007 SHALL have port wave_freq, input, 16 bits: the frequency word, sampled when freq_valid=1.
REQ-008 SHALL have port fifo_rd_count, input, 14 bits: the waveform FIFO fill level.
REQ-009 SHALL have port fifo_rd_en, output, 1 bit: the waveform FIFO read strobe (FIFO read latency is 1 cycle).
REQ-010 SHALL have port fifo_dout, input, 8 bits: the waveform FIFO read data.
REQ-011 SHALL have port tx_start_en, output, 1 bit: one-cycle start pulse to the UDP engine.
REQ-012 SHALL have port tx_byte_num, output, 16 bits: the payload length of the current packet.
REQ-013 SHALL have port udp_tx_req, input, 1 bit: the UDP engine's per-byte data request.
REQ-014 SHALL have port udp_tx_data, output, 8 bits: the payload byte, valid on the cycle after udp_tx_req.
REQ-015 SHALL have port udp_tx_done, input, 1 bit: one-cycle packet-complete strobe.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port freq_ovr_cnt, output, 8 bits: a saturating count of overwritten, unsent frequency words.
REQ-018 SHALL have port timeout_err, output, 1 bit: a sticky flag, set on a done-timeout.

Function
REQ-019 SHALL, on freq_valid, latch wave_freq into freq_hold and set freq_pend; if freq_pend is already 1 and not being consumed that cycle, it SHALL overwrite freq_hold and increment freq_ovr_cnt, saturating at 255.
REQ-020 SHALL treat the wave requester as eligible when fifo_rd_count >= WAVE_BYTES.
REQ-021 SHALL implement states IDLE, GAP, FREQ_TX, WAVE_TX.
REQ-022 SHALL transition IDLE->FREQ_TX or IDLE->WAVE_TX when at least one requester is eligible; with both eligible, it SHALL grant the one not served last (round-robin; after reset, freq wins).
REQ-023 SHALL, on the cycle of the grant, pulse tx_start_en for exactly 1 cycle and load tx_byte_num with 2 (FREQ) or WAVE_BYTES (WAVE); tx_byte_num SHALL hold until the state returns to IDLE.
REQ-024 SHALL, on a FREQ grant, copy freq_hold into a send register and clear freq_pend on the same cycle; a freq_valid on that cycle SHALL re-set freq_pend without counting an overrun.
REQ-025 SHALL, in FREQ_TX, drive udp_tx_data on the cycle after the 1st udp_tx_req to send[15:8], and after the 2nd to send[7:0]; any further requests SHALL return 0x00.
REQ-026 SHALL, in WAVE_TX, set fifo_rd_en = udp_tx_req combinationally while rd_cnt < WAVE_BYTES, with udp_tx_data = fifo_dout; fifo_rd_en SHALL never assert outside WAVE_TX.
REQ-027 SHALL increment a 14-bit rd_cnt per fifo_rd_en and clear it on the grant; requests beyond WAVE_BYTES SHALL produce no read and udp_tx_data = 0x00.
REQ-028 SHALL, on udp_tx_done in FREQ_TX or WAVE_TX, enter GAP; GAP SHALL last GAP_CYCLES cycles (GAP_CYCLES=0 means the state is left the next cycle), then return to IDLE.
REQ-029 SHALL ignore udp_tx_done while in IDLE or GAP.
REQ-030 SHALL run a 20-bit timeout counter in FREQ_TX and WAVE_TX; on reaching TIMEOUT_CYCLES without udp_tx_done, it SHALL set timeout_err and enter GAP. A pending freq word SHALL be retained; unread FIFO data is left in place.
REQ-031 SHALL keep udp_tx_data at 0x00 in IDLE and GAP.

Reset
REQ-032 SHALL, while rst_n=0, force: state=IDLE; tx_start_en=0; fifo_rd_en=0; tx_byte_num=0; udp_tx_data=0; busy=0; freq_pend=0; freq_ovr_cnt=0; timeout_err=0; round-robin pointer to favour freq; all counters to 0.
REQ-033 SHALL, on reset asserted mid-packet, abort immediately with no further fifo_rd_en; after release, it SHALL wait in IDLE for a new eligible requester.

Verification
REQ-034 SHALL be verified with: freq_valid with wave_freq=0x1234 while idle -> tx_start_en pulse, tx_byte_num=2, udp_tx_data 0x12 then 0x34 after the two reqs.
REQ-035 SHALL be verified with: fifo_rd_count=1024, 1024 reqs, FIFO bytes 0..255 repeating -> exactly 1024 fifo_rd_en, data in order, then GAP of 16 cycles.
REQ-036 SHALL be verified with: both eligible at the same time -> FREQ, WAVE, FREQ grant order across three packets.
REQ-037 SHALL be verified with: three freq_valid strobes during a WAVE packet -> freq_ovr_cnt=2, last value sent next.
REQ-038 SHALL be verified with: udp_tx_done withheld, TIMEOUT_CYCLES=100 -> timeout_err=1 at cycle 100, then GAP then IDLE.
REQ-039 SHALL be verified with: rst_n low at byte 500 of a WAVE packet -> all outputs at reset values on that cycle, no fifo_rd_en afterwards.
